// File: rtl/hfg_feature_buffer_pkg.sv
// Shared definitions for the ping-pong feature result buffer: default widths,
// bank-state encoding and the debug snapshot of the bank-control state.
package hfg_feature_buffer_pkg;

  localparam int HFG_DATA_W = 32;
  localparam int HFG_ADDR_W = 7;

  // FILLING is not a stored state: the bank selected by wb is filling
  // whenever it is EMPTY.
  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_e;

  typedef struct packed {
    bank_state_e bank1;
    bank_state_e bank0;
    logic        wb;
    logic        rb;
    logic        close_edge;
  } fb_dbg_t;

endpackage

// File: rtl/hfg_feature_buffer_if.sv
// Generator write port, classifier read port and status flags of the
// feature buffer, bundled so both producer and consumer share one bus.
interface hfg_feature_buffer_if #(
  parameter int DATA_W = hfg_feature_buffer_pkg::HFG_DATA_W,
  parameter int ADDR_W = hfg_feature_buffer_pkg::HFG_ADDR_W
);

  // Handshake rules: a strobe (iWrreq, iRdreq, iRelease, rising iFull_W) is
  // accepted only in a cycle where its qualifying status is high -- oReady_W
  // for writes and closes, oAvail_R for reads and releases. Writes or closes
  // offered while oReady_W is low are dropped and set the sticky oErr; reads
  // or releases offered while oAvail_R is low are silently ignored. There is
  // no back-pressure beyond these levels; an accepted read returns one word
  // with oValid_R high exactly one cycle later.
  logic              iWrreq;
  logic [ADDR_W-1:0] iAddr_W;
  logic [DATA_W-1:0] iFeature;
  logic              iFull_W;
  logic              oReady_W;
  logic              oAvail_R;
  logic              iRdreq;
  logic [ADDR_W-1:0] iAddr_R;
  logic [DATA_W-1:0] oFeature;
  logic              oValid_R;
  logic              iRelease;
  logic              oErr;

  modport master (
    output iWrreq, iAddr_W, iFeature, iFull_W, iRdreq, iAddr_R, iRelease,
    input  oReady_W, oAvail_R, oFeature, oValid_R, oErr
  );

  modport slave (
    input  iWrreq, iAddr_W, iFeature, iFull_W, iRdreq, iAddr_R, iRelease,
    output oReady_W, oAvail_R, oFeature, oValid_R, oErr
  );

endinterface

// File: rtl/hfg_fbr_bank.sv
// One feature bank: simple dual-port RAM with a write port and a registered
// read port. The read register holds its value when no read is issued.
module hfg_fbr_bank #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Storage array; contents are not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read data, cleared by reset so the output starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/hfg_feature_buffer.sv
// Ping-pong feature buffer: the generator fills bank[wb] while the classifier
// reads bank[rb]. A bank is closed by a rising edge of iFull_W and returned
// to the generator by iRelease.
module hfg_feature_buffer
  import hfg_feature_buffer_pkg::*;
#(
  parameter int DATA_W = HFG_DATA_W,
  parameter int ADDR_W = HFG_ADDR_W
) (
  input  logic                    iClk,
  input  logic                    iReset_n,
  hfg_feature_buffer_if.slave     bus,
  output fb_dbg_t                 dbg
);

  bank_state_e bank_q [2];
  bank_state_e bank_d [2];
  logic wb_q, wb_d, rb_q, rb_d, err_q, err_d;
  logic full_r_q, full_p_q;
  logic rd_bank_q, valid_q;
  logic ready_w, avail_r, close_edge;
  logic wr_ok, close_ok, rd_ok, rel_ok;
  logic [DATA_W-1:0] rdata0, rdata1;

  // Bank-control state register plus the iFull_W edge-detect pipeline and
  // read-side bookkeeping.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      bank_q[0] <= BANK_EMPTY;
      bank_q[1] <= BANK_EMPTY;
      wb_q      <= 1'b0;
      rb_q      <= 1'b0;
      err_q     <= 1'b0;
      full_r_q  <= 1'b0;
      full_p_q  <= 1'b0;
      rd_bank_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
      wb_q      <= wb_d;
      rb_q      <= rb_d;
      err_q     <= err_d;
      full_r_q  <= bus.iFull_W;
      full_p_q  <= full_r_q;
      valid_q   <= rd_ok;
      if (rd_ok) rd_bank_q <= rb_q;
    end
  end

  // Status levels and accepted strobes derived from the current state.
  always_comb begin
    ready_w    = (bank_q[wb_q] != BANK_FULL);
    avail_r    = (bank_q[rb_q] == BANK_FULL);
    close_edge = full_r_q & ~full_p_q;
    wr_ok      = bus.iWrreq & ready_w;
    close_ok   = close_edge & ready_w;
    rd_ok      = bus.iRdreq & avail_r;
    rel_ok     = bus.iRelease & avail_r;
  end

  // Next bank states: close and release touch different banks, since a
  // closable bank is never FULL and a releasable bank always is.
  always_comb begin
    bank_d[0] = bank_q[0];
    bank_d[1] = bank_q[1];
    wb_d      = wb_q;
    rb_d      = rb_q;
    err_d     = err_q | ((bus.iWrreq | close_edge) & ~ready_w);
    if (close_ok) begin
      bank_d[wb_q] = BANK_FULL;
      wb_d         = ~wb_q;
    end
    if (rel_ok) begin
      bank_d[rb_q] = BANK_EMPTY;
      rb_d         = ~rb_q;
    end
  end

  hfg_fbr_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank0 (
    .clk   (iClk),
    .rst_n (iReset_n),
    .we    (wr_ok & ~wb_q),
    .waddr (bus.iAddr_W),
    .wdata (bus.iFeature),
    .re    (rd_ok & ~rb_q),
    .raddr (bus.iAddr_R),
    .rdata (rdata0)
  );

  hfg_fbr_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank1 (
    .clk   (iClk),
    .rst_n (iReset_n),
    .we    (wr_ok & wb_q),
    .waddr (bus.iAddr_W),
    .wdata (bus.iFeature),
    .re    (rd_ok & rb_q),
    .raddr (bus.iAddr_R),
    .rdata (rdata1)
  );

  assign bus.oReady_W   = ready_w;
  assign bus.oAvail_R   = avail_r;
  assign bus.oErr       = err_q;
  assign bus.oValid_R   = valid_q;
  assign bus.oFeature   = rd_bank_q ? rdata1 : rdata0;

  assign dbg.bank0      = bank_q[0];
  assign dbg.bank1      = bank_q[1];
  assign dbg.wb         = wb_q;
  assign dbg.rb         = rb_q;
  assign dbg.close_edge = close_edge;

endmodule

// File: tb/tb_hfg_feature_buffer.sv
// Bench for the ping-pong feature buffer: directed scenarios plus random
// traffic, all checked against a bank-level reference model.
module tb_hfg_feature_buffer;
  import hfg_feature_buffer_pkg::*;

  localparam int DW    = HFG_DATA_W;
  localparam int AW    = HFG_ADDR_W;
  localparam int DEPTH = 1 << AW;

  // Clock and reset
  logic iClk = 1'b0;
  logic iReset_n = 1'b0;
  always #5 iClk = ~iClk;

  hfg_feature_buffer_if bus ();
  fb_dbg_t dbg;

  hfg_feature_buffer dut (
    .iClk     (iClk),
    .iReset_n (iReset_n),
    .bus      (bus),
    .dbg      (dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: two banks of words, a full flag per bank, fill/read
  // pointers and the registered copies of iFull_W.
  logic [DW-1:0] m_mem [2][DEPTH];
  bit            m_wr  [2][DEPTH];
  bit            m_full [2];
  bit            m_wb, m_rb, m_err, m_fr, m_fp, m_valid;
  logic [DW-1:0] m_feat;
  logic [DW-1:0] exp_q [$];
  bit            exp_known_q [$];

  task automatic model_reset();
    m_full[0] = 0; m_full[1] = 0;
    m_wb = 0; m_rb = 0; m_err = 0; m_fr = 0; m_fp = 0; m_valid = 0;
    m_feat = '0;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < DEPTH; a++) m_wr[b][a] = 0;
    exp_q.delete();
    exp_known_q.delete();
  endtask

  task automatic model_edge();
    bit ready, avail, close_c;
    ready   = !m_full[m_wb];
    avail   = m_full[m_rb];
    close_c = m_fr && !m_fp;
    if (bus.iWrreq) begin
      if (ready) begin
        m_mem[m_wb][bus.iAddr_W] = bus.iFeature;
        m_wr[m_wb][bus.iAddr_W]  = 1;
      end else m_err = 1;
    end
    if (close_c) begin
      if (ready) begin
        m_full[m_wb] = 1;
        m_wb = !m_wb;
      end else m_err = 1;
    end
    m_valid = 0;
    if (bus.iRdreq && avail) begin
      m_feat  = m_mem[m_rb][bus.iAddr_R];
      m_valid = 1;
      exp_q.push_back(m_feat);
      exp_known_q.push_back(m_wr[m_rb][bus.iAddr_R]);
    end
    if (bus.iRelease && avail) begin
      m_full[m_rb] = 0;
      m_rb = !m_rb;
    end
    m_fp = m_fr;
    m_fr = bus.iFull_W;
  endtask

  // Driver tasks
  task automatic idle_inputs();
    bus.iWrreq = 0; bus.iAddr_W = '0; bus.iFeature = '0; bus.iFull_W = 0;
    bus.iRdreq = 0; bus.iAddr_R = '0; bus.iRelease = 0;
  endtask

  task automatic step();
    model_edge();
    @(posedge iClk);
    #1;
  endtask

  task automatic fill_bank(input int last_addr, input bit use_rand);
    for (int k = 0; k <= last_addr; k++) begin
      bus.iWrreq   = 1;
      bus.iAddr_W  = AW'(k);
      bus.iFeature = use_rand ? DW'($urandom) : DW'(k * 3);
      step();
    end
    bus.iWrreq = 0;
  endtask

  task automatic close_bank();
    bus.iFull_W = 1;
    step();
    bus.iFull_W = 0;
    step();
  endtask

  task automatic read_check(input int addr, input string name);
    logic [DW-1:0] e;
    bus.iRdreq  = 1;
    bus.iAddr_R = AW'(addr);
    step();
    bus.iRdreq  = 0;
    n_checks++;
    if (bus.oValid_R !== 1'b1 || exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s valid: got %b required 1 (queued %0d)", name, bus.oValid_R, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      void'(exp_known_q.pop_front());
      n_checks++;
      if (bus.oFeature !== e) begin
        n_fail++;
        $display("FAIL %s data addr %0d: got %h required %h", name, addr, bus.oFeature, e);
      end
    end
  endtask

  // Scenarios
  task automatic test_reset();
    idle_inputs();
    iReset_n = 0;
    model_reset();
    repeat (2) @(posedge iClk);
    #1;
    iReset_n = 1;
    n_checks++; if (bus.oReady_W !== 1'b1) begin n_fail++; $display("FAIL reset oReady_W: got %b required 1", bus.oReady_W); end
    n_checks++; if (bus.oAvail_R !== 1'b0) begin n_fail++; $display("FAIL reset oAvail_R: got %b required 0", bus.oAvail_R); end
    n_checks++; if (bus.oFeature !== '0)   begin n_fail++; $display("FAIL reset oFeature: got %h required 0", bus.oFeature); end
    n_checks++; if (bus.oValid_R !== 1'b0) begin n_fail++; $display("FAIL reset oValid_R: got %b required 0", bus.oValid_R); end
    n_checks++; if (bus.oErr !== 1'b0)     begin n_fail++; $display("FAIL reset oErr: got %b required 0", bus.oErr); end
  endtask

  task automatic test_fill_read();
    int ra[3];
    ra = '{0, 1, 127};
    fill_bank(DEPTH - 1, 0);
    bus.iFull_W = 1;
    step();
    n_checks++; if (bus.oAvail_R !== 1'b0) begin n_fail++; $display("FAIL fill early oAvail_R: got %b required 0", bus.oAvail_R); end
    bus.iFull_W = 0;
    step();
    n_checks++; if (bus.oAvail_R !== m_full[m_rb] || !m_full[m_rb]) begin n_fail++; $display("FAIL fill oAvail_R: got %b required 1", bus.oAvail_R); end
    n_checks++; if (bus.oReady_W !== 1'b1) begin n_fail++; $display("FAIL fill oReady_W: got %b required 1", bus.oReady_W); end
    for (int i = 0; i < 3; i++) read_check(ra[i], "b2b_read");
    step();
    n_checks++; if (bus.oValid_R !== 1'b0) begin n_fail++; $display("FAIL read idle oValid_R: got %b required 0", bus.oValid_R); end
    n_checks++; if (bus.oFeature !== m_feat) begin n_fail++; $display("FAIL read hold oFeature: got %h required %h", bus.oFeature, m_feat); end
  endtask

  task automatic test_overflow();
    fill_bank(DEPTH - 1, 1);
    close_bank();
    n_checks++; if (bus.oReady_W !== 1'b0) begin n_fail++; $display("FAIL both full oReady_W: got %b required 0", bus.oReady_W); end
    n_checks++; if (bus.oErr !== 1'b0) begin n_fail++; $display("FAIL pre-overflow oErr: got %b required 0", bus.oErr); end
    bus.iWrreq = 1; bus.iAddr_W = AW'(5); bus.iFeature = 32'hDEADBEEF;
    step();
    bus.iWrreq = 0;
    n_checks++; if (bus.oErr !== m_err || !m_err) begin n_fail++; $display("FAIL overflow oErr: got %b required 1", bus.oErr); end
    read_check(5, "overflow_bank0");
  endtask

  task automatic test_release_both_full();
    bus.iRelease = 1;
    step();
    bus.iRelease = 0;
    n_checks++; if (bus.oReady_W !== 1'b1) begin n_fail++; $display("FAIL release oReady_W: got %b required 1", bus.oReady_W); end
    n_checks++; if (bus.oAvail_R !== 1'b1) begin n_fail++; $display("FAIL release oAvail_R: got %b required 1", bus.oAvail_R); end
    read_check(5, "release_bank1");
    read_check(int'($urandom_range(0, DEPTH - 1)), "release_bank1_rand");
  endtask

  task automatic test_close_and_release();
    fill_bank(DEPTH - 3, 1);
    bus.iWrreq = 1; bus.iAddr_W = AW'(DEPTH - 2); bus.iFeature = DW'($urandom);
    bus.iFull_W = 1;
    step();
    bus.iFull_W = 0;
    bus.iAddr_W = AW'(DEPTH - 1); bus.iFeature = DW'($urandom);
    bus.iRelease = 1;
    step();
    bus.iWrreq = 0; bus.iRelease = 0;
    n_checks++; if (bus.oAvail_R !== 1'b1) begin n_fail++; $display("FAIL close+release oAvail_R: got %b required 1", bus.oAvail_R); end
    n_checks++; if (bus.oReady_W !== 1'b1) begin n_fail++; $display("FAIL close+release oReady_W: got %b required 1", bus.oReady_W); end
    n_checks++; if (dbg.wb !== m_wb || dbg.rb !== m_rb) begin n_fail++; $display("FAIL close+release ptrs: got wb=%b rb=%b required wb=%b rb=%b", dbg.wb, dbg.rb, m_wb, m_rb); end
    read_check(DEPTH - 1, "close_cycle_write");
    read_check(0, "close_bank_word0");
  endtask

  task automatic test_idle_ops();
    logic [DW-1:0] held;
    bus.iRelease = 1;
    step();
    bus.iRelease = 0;
    n_checks++; if (bus.oAvail_R !== 1'b0) begin n_fail++; $display("FAIL idle oAvail_R: got %b required 0", bus.oAvail_R); end
    held = m_feat;
    bus.iRdreq = 1; bus.iRelease = 1; bus.iAddr_R = AW'($urandom_range(0, DEPTH - 1));
    step();
    bus.iRdreq = 0; bus.iRelease = 0;
    n_checks++; if (bus.oValid_R !== 1'b0) begin n_fail++; $display("FAIL idle oValid_R: got %b required 0", bus.oValid_R); end
    n_checks++; if (bus.oFeature !== held) begin n_fail++; $display("FAIL idle oFeature hold: got %h required %h", bus.oFeature, held); end
    n_checks++; if (dbg.rb !== m_rb) begin n_fail++; $display("FAIL idle rb: got %b required %b", dbg.rb, m_rb); end
    n_checks++; if (bus.oErr !== m_err) begin n_fail++; $display("FAIL idle oErr: got %b required %b", bus.oErr, m_err); end
  endtask

  task automatic test_reset_mid();
    fill_bank(60, 1);
    #2 iReset_n = 0;
    #1;
    n_checks++; if (bus.oErr !== 1'b0 || bus.oReady_W !== 1'b1 || bus.oAvail_R !== 1'b0) begin
      n_fail++; $display("FAIL mid-fill reset: got err=%b rdy=%b avl=%b required 0 1 0", bus.oErr, bus.oReady_W, bus.oAvail_R); end
    model_reset();
    idle_inputs();
    @(posedge iClk); #1;
    iReset_n = 1;
    fill_bank(DEPTH - 1, 1);
    close_bank();
    bus.iRdreq = 1; bus.iAddr_R = AW'(7);
    step();
    bus.iRdreq = 0;
    #2 iReset_n = 0;
    #1;
    n_checks++; if (bus.oValid_R !== 1'b0 || bus.oFeature !== '0 || bus.oAvail_R !== 1'b0) begin
      n_fail++; $display("FAIL mid-read reset: got vld=%b dat=%h avl=%b required 0 0 0", bus.oValid_R, bus.oFeature, bus.oAvail_R); end
    model_reset();
    @(posedge iClk); #1;
    iReset_n = 1;
    fill_bank(DEPTH - 1, 1);
    close_bank();
    read_check(0, "refill");
    read_check(60, "refill");
    read_check(DEPTH - 1, "refill");
    bus.iRelease = 1;
    step();
    bus.iRelease = 0;
    n_checks++; if (bus.oAvail_R !== 1'b0 || bus.oReady_W !== 1'b1) begin
      n_fail++; $display("FAIL refill release: got avl=%b rdy=%b required 0 1", bus.oAvail_R, bus.oReady_W); end
  endtask

  task automatic test_random();
    logic [DW-1:0] e;
    bit            known;
    for (int c = 0; c < 2500; c++) begin
      bus.iWrreq   = ($urandom_range(0, 3) != 0);
      bus.iAddr_W  = AW'($urandom_range(0, DEPTH - 1));
      bus.iFeature = DW'($urandom);
      if ($urandom_range(0, 39) == 0) bus.iFull_W = ~bus.iFull_W;
      bus.iRdreq   = ($urandom_range(0, 1) == 1);
      bus.iAddr_R  = AW'($urandom_range(0, DEPTH - 1));
      bus.iRelease = ($urandom_range(0, 29) == 0);
      step();
      n_checks++;
      if (bus.oValid_R !== m_valid || bus.oReady_W !== !m_full[m_wb] ||
          bus.oAvail_R !== m_full[m_rb] || bus.oErr !== m_err) begin
        n_fail++;
        $display("FAIL random status cycle %0d: got vld=%b rdy=%b avl=%b err=%b required %b %b %b %b",
                 c, bus.oValid_R, bus.oReady_W, bus.oAvail_R, bus.oErr,
                 m_valid, !m_full[m_wb], m_full[m_rb], m_err);
      end
      if (m_valid && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        known = exp_known_q.pop_front();
        if (known) begin
          n_checks++;
          if (bus.oFeature !== e) begin
            n_fail++;
            $display("FAIL random data cycle %0d: got %h required %h", c, bus.oFeature, e);
          end
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_fill_read();
    test_overflow();
    test_release_both_full();
    test_close_and_release();
    test_idle_ops();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hfg_feature_buffer.md
# hfg_feature_buffer

Double-buffered (ping-pong) feature result buffer sitting downstream of the 19x19 Haar feature generator. It accepts one window's worth of 32-bit normalized features over the generator's FBR write port, and presents completed windows to the cascade classifier through a registered random-access read port. While the classifier reads one bank, the generator fills the other, so feature generation and classification overlap across consecutive windows.

## Interface
Parameters:
- DATA_W, 32, feature word width
- ADDR_W, 7, feature address width (per-bank depth = 2**ADDR_W = 128)

Ports:
- iClk  in  1  single clock, all logic rising-edge
- iReset_n  in  1  asynchronous, active-low reset
- iWrreq  in  1  write strobe from generator (driven by its finish pulse)
- iAddr_W  in  ADDR_W  write address within current fill bank
- iFeature  in  DATA_W  feature word to store
- iFull_W  in  1  generator's window-complete level; rising edge closes the fill bank
- oReady_W  out  1  a bank is available for filling; generator must not start a window while low
- oAvail_R  out  1  a completed window is readable
- iRdreq  in  1  classifier read strobe
- iAddr_R  in  ADDR_W  read address within current read bank
- oFeature  out  DATA_W  read data, registered
- oValid_R  out  1  oFeature valid (one-cycle pulse per accepted read)
- iRelease  in  1  one-cycle pulse: classifier done with read bank
- oErr  out  1  sticky: write or close attempted with no fill bank

## Operation
- Two banks, each state EMPTY -> FILLING -> FULL -> EMPTY. Fill pointer wb, read pointer rb (1 bit each).
- FILLING is entered implicitly when wb bank is EMPTY; oReady_W = (bank[wb] != FULL).
- iWrreq with oReady_W high: store iFeature at bank[wb][iAddr_W]. Same address twice overwrites; no ordering requirement on addresses.
- iFull_W rising edge (registered copy, edge = iFull_W & ~prev) with oReady_W high: bank[wb] <= FULL, wb toggles. A write in the same cycle as the edge lands in the closing bank.
- iWrreq or close edge with oReady_W low: dropped, oErr set; cleared only by reset.
- oAvail_R = (bank[rb] == FULL).
- iRdreq with oAvail_R high: read bank[rb][iAddr_R]. iRdreq with oAvail_R low: ignored, oValid_R stays 0, oFeature holds.
- iRelease with oAvail_R high: bank[rb] <= EMPTY, rb toggles. iRelease with oAvail_R low: ignored.
- Simultaneous close and release: both apply in the same cycle, on their respective banks; if wb==rb bank (both banks previously full, now one freed) the freed bank becomes the new fill bank next cycle.
- iRdreq and iRelease in the same cycle: read served from the bank being released (data valid next cycle).

## Timing
- Reset values: both banks EMPTY, wb=0, rb=0, oReady_W=1, oAvail_R=0, oFeature=0, oValid_R=0, oErr=0; RAM contents undefined.
- Write: stored at the iWrreq edge; readable once bank is FULL.
- Close: edge sampled at clock N; oAvail_R rises after N+1 (if read side idle); oReady_W drops after N+1 only if other bank is FULL.
- Read latency 1: iRdreq at edge N -> oFeature/oValid_R valid after edge N+1; back-to-back reads give one word per cycle.
- Release at edge N -> oAvail_R reflects the other bank after N+1; oReady_W rises after N+1 if it was low.
- Reset asserted mid-window: all state returns to reset values immediately; partially filled or unread windows are discarded.

## Structure
- Shared package: DATA_W, ADDR_W defaults, bank-state encoding (EMPTY, FULL; FILLING implied by wb).
- Sub-module hfg_fbr_bank: simple dual-port RAM, 2**ADDR_W x DATA_W, one write port, one registered read port; instantiated twice, write/read enables steered by wb/rb.

## Test plan
- Reset then fill bank 0 with addr k -> k*3, raise iFull_W -> oAvail_R=1 one cycle after edge; read addrs 0,1,127 back-to-back -> 0x0,0x3,0x17D on consecutive cycles with oValid_R=1.
- Fill both banks without release -> oReady_W=0; extra iWrreq with 0xDEADBEEF -> dropped, oErr=1, bank contents unchanged.
- Both FULL, iRelease -> oReady_W=1 next cycle, oAvail_R stays 1 showing bank 1 data (read addr 5 returns bank-1 value).
- Close edge and iRelease in same cycle with one bank FULL -> next cycle oAvail_R=1 on newly closed bank, oReady_W=1.
- iRdreq and iRelease on oAvail_R=0 -> oValid_R=0, rb unchanged, oErr unchanged.
- Assert iReset_n low mid-fill (addr 60) and mid-read -> all outputs at reset values asynchronously; refill after release returns correct data.
